alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; must equal `REG_WIDTH.
REQ-002 SHALL have parameter FUNC_W, default `OPP_WIDTH, ALU func code width.
REQ-003 SHALL have ports: phi1 in 1, the single clock, rising edge; reset_n in 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports: req in 1, op request; op in 4, operation code; a in DATA_W; b in DATA_W; carry_in in 1, current C flag; dec_mode in 1, D flag.
REQ-005 SHALL have ports: busy out 1; done out 1, one-cycle completion pulse; result out DATA_W; result_we out 1; flags out 4, {N,V,Z,C}; flags_mask out 4, which flags to update; err out 1.
REQ-006 SHALL have ALU-side ports: alu_a out DATA_W; alu_b out DATA_W; alu_func out FUNC_W; alu_carry_in out 1; alu_add in DATA_W; alu_carry_out in 1; alu_wout in 1.

Function
REQ-007 SHALL decode op: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 ROL, 7 INC, 8 DEC, 9 CMP; 10-15 illegal.
REQ-008 SHALL use FSM states IDLE, ISSUE, CAPT, ADJ_ISSUE, ADJ_CAPT.
REQ-009 SHALL, in IDLE with req=1, latch op/a/b/carry_in/dec_mode, set busy=1, go ISSUE; busy=0 only in IDLE.
REQ-010 SHALL ignore req while busy=1 (no queuing).
REQ-011 SHALL, in ISSUE, drive ALU: ADC a,b,`SUM,C; SBC a,~b,`SUM,C; AND/ORA/EOR a,b,`AND/`OR/`XOR,0; ASL a,a,`SUM,0; ROL a,a,`SUM,C; INC a,0,`SUM,1; DEC a,8'hFF,`SUM,0; CMP a,~b,`SUM,1; then go CAPT.
REQ-012 SHALL, in CAPT, sample alu_add/alu_carry_out (ALU result is registered, one-cycle latency).
REQ-013 SHALL, outside ISSUE/ADJ_ISSUE, drive alu_a=0, alu_b=0, alu_func=`SUM, alu_carry_in=0.
REQ-014 SHALL compute V = (a[7]==b_eff[7]) && (r[7]!=a[7]), b_eff the operand actually sent; N = r[7]; Z = (r==0); C = alu_carry_out.
REQ-015 SHALL set flags_mask: ADC/SBC 4'b1111; AND/ORA/EOR/INC/DEC 4'b1010; ASL/ROL/CMP 4'b1011.
REQ-016 SHALL set result_we=1 for all legal ops except CMP (0).
REQ-017 SHALL, from CAPT for binary ops, register result/flags, pulse done=1 one cycle, return IDLE: done exactly 3 cycles after accepting edge.
REQ-018 SHALL accept a new req in the IDLE cycle coincident with done=1 (back-to-back).
REQ-019 SHALL, for illegal op, skip ALU, go IDLE next edge, pulse done=1 and err=1 together, result_we=0, flags_mask=0.
REQ-020 SHALL, if alu_wout=0 in CAPT/ADJ_CAPT, pulse err=1 with done, result_we=0, flags_mask=0.
REQ-021 SHALL hold result/flags/flags_mask/result_we stable from done until next done; done/err are 0 otherwise.

Reset
REQ-022 SHALL, on reset_n=0 at any time incl. mid-operation, immediately force IDLE, busy=0, done=0, err=0, result=0, result_we=0, flags=0, flags_mask=0, ALU drives per REQ-013.
REQ-023 SHALL not accept req until the first edge after reset_n rises.

Configuration
REQ-024 SHALL implement decimal adjust only when macro ALU_SEQ_DECIMAL_EN is defined.
REQ-025 With ALU_SEQ_DECIMAL_EN, ADC/SBC with dec_mode=1 SHALL go CAPT->ADJ_ISSUE->ADJ_CAPT, adding adjust (ADC: +06 if low-nibble>9 or half-carry, +60 if high>9 or carry; SBC: +FA if no half-carry, +A0 if no carry); C = binary carry OR high adjust (ADC), binary carry (SBC); N,Z from adjusted result; V from binary pass; done 5 cycles after accept.
REQ-026 Without ALU_SEQ_DECIMAL_EN, dec_mode SHALL be ignored, ADJ states absent, all ops binary.

Verification
REQ-027 ADC a=50 b=50 C=0 -> result A0, flags N1 V1 Z0 C0, mask 1111, done at accept+3.
REQ-028 SBC a=00 b=01 C=1 -> FF, N1 V0 Z0 C0; CMP a=10 b=10 -> result_we=0, Z1 C1, mask 1011.
REQ-029 (DECIMAL_EN) ADC dec a=19 b=28 C=0 -> 47 C0 at accept+5; a=99 b=01 -> 00, Z1 C1.
REQ-030 req held during busy -> ignored; req in done cycle -> accepted, second done 3 cycles later.
REQ-031 reset_n low during ADJ_ISSUE -> all outputs 0 same cycle; op=F -> done+err at accept+1, mask 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer around an external registered ALU. It handles operand steering,
// flag generation, illegal-op and ALU-fault reporting. Define ALU_SEQ_DECIMAL_EN to enable BCD adjust for ADC/SBC.

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef OPP_WIDTH
`define OPP_WIDTH 3
`endif
`ifndef SUM
`define SUM 0
`endif
`ifndef AND
`define AND 1
`endif
`ifndef OR
`define OR 2
`endif
`ifndef XOR
`define XOR 3
`endif

module alu_sequencer #(
    parameter int DATA_W = `REG_WIDTH,
    parameter int FUNC_W = `OPP_WIDTH
) (
    input  logic              phi1,
    input  logic              reset_n,
    input  logic              req,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    input  logic              dec_mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              result_we,
    output logic [3:0]        flags,
    output logic [3:0]        flags_mask,
    output logic              err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUNC_W-1:0] alu_func,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_add,
    input  logic              alu_carry_out,
    input  logic              alu_wout
);

    // state      | meaning
    // IDLE       | waiting for req (accepts only when no completion is pending)
    // ISSUE      | operands driven to the ALU
    // CAPT       | binary ALU result available
    // ADJ_ISSUE  | decimal adjust constant driven to the ALU
    // ADJ_CAPT   | adjusted result available
    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, ADJ_ISSUE, ADJ_CAPT} state_t;

    localparam logic [3:0] OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2, OP_ORA = 4'd3,
                           OP_EOR = 4'd4, OP_ASL = 4'd5, OP_ROL = 4'd6, OP_INC = 4'd7,
                           OP_DEC = 4'd8, OP_CMP = 4'd9;
    localparam logic [FUNC_W-1:0] F_SUM = FUNC_W'(`SUM);
    localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(`AND);
    localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(`OR);
    localparam logic [FUNC_W-1:0] F_XOR = FUNC_W'(`XOR);
    localparam int MSB = DATA_W - 1;

    state_t            r_state;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a, r_b;
    logic              r_cin;
    logic              r_fin;
    logic [DATA_W-1:0] r_p_result, r_result;
    logic [3:0]        r_p_flags, r_flags, r_p_mask, r_mask;
    logic              r_p_we, r_we, r_p_err, r_err, r_done;

    logic [DATA_W-1:0] w_beff;
    logic [FUNC_W-1:0] w_func;
    logic              w_cin;
    logic [3:0]        w_mask;
    logic              w_we;
    logic              w_n, w_v, w_z, w_c, w_bad;
    logic              w_go_adj, w_finish;

`ifdef ALU_SEQ_DECIMAL_EN
    logic              r_dec;
    logic [DATA_W-1:0] r_bin;
    logic              r_bcout, r_werr;
    logic              w_hc, w_lo_adj, w_hi_adj;
    logic [DATA_W-1:0] w_adj;

    // High-digit correction for ADC keys off the whole binary sum exceeding 99,
    // so a low-digit carry into a 9 (e.g. 99+01) also adjusts the high digit.
    always_comb begin
        w_hc     = r_a[4] ^ w_beff[4] ^ r_bin[4];
        w_lo_adj = 1'b0;
        w_hi_adj = 1'b0;
        w_adj    = '0;
        if (r_op == OP_ADC) begin
            w_lo_adj = (r_bin[3:0] > 4'd9) || w_hc;
            w_hi_adj = (r_bin > DATA_W'(8'h99)) || r_bcout;
            w_adj    = DATA_W'({w_hi_adj ? 4'h6 : 4'h0, w_lo_adj ? 4'h6 : 4'h0});
        end else begin
            w_lo_adj = !w_hc;
            w_hi_adj = !r_bcout;
            w_adj    = DATA_W'((w_lo_adj ? 8'hFA : 8'h00) + (w_hi_adj ? 8'hA0 : 8'h00));
        end
    end

    assign w_go_adj = r_dec && (r_op == OP_ADC || r_op == OP_SBC);
`else
    logic w_unused_dec;
    assign w_unused_dec = dec_mode;
    assign w_go_adj     = 1'b0;
`endif

    always_comb begin
        w_beff = r_b;
        w_func = F_SUM;
        w_cin  = 1'b0;
        w_mask = 4'b0000;
        w_we   = 1'b1;
        case (r_op)
            OP_ADC: begin w_cin = r_cin; w_mask = 4'b1111; end
            OP_SBC: begin w_beff = ~r_b; w_cin = r_cin; w_mask = 4'b1111; end
            OP_AND: begin w_func = F_AND; w_mask = 4'b1010; end
            OP_ORA: begin w_func = F_OR;  w_mask = 4'b1010; end
            OP_EOR: begin w_func = F_XOR; w_mask = 4'b1010; end
            OP_ASL: begin w_beff = r_a; w_mask = 4'b1011; end
            OP_ROL: begin w_beff = r_a; w_cin = r_cin; w_mask = 4'b1011; end
            OP_INC: begin w_beff = '0; w_cin = 1'b1; w_mask = 4'b1010; end
            OP_DEC: begin w_beff = '1; w_mask = 4'b1010; end
            OP_CMP: begin w_beff = ~r_b; w_cin = 1'b1; w_mask = 4'b1011; w_we = 1'b0; end
            default: w_we = 1'b0;
        endcase
    end

    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_func     = F_SUM;
        alu_carry_in = 1'b0;
        if (r_state == ISSUE) begin
            alu_a        = r_a;
            alu_b        = w_beff;
            alu_func     = w_func;
            alu_carry_in = w_cin;
        end
`ifdef ALU_SEQ_DECIMAL_EN
        else if (r_state == ADJ_ISSUE) begin
            alu_a = r_bin;
            alu_b = w_adj;
        end
`endif
    end

    // Flags of the final pass; V always reflects the binary pass.
    always_comb begin
        w_n   = alu_add[MSB];
        w_z   = (alu_add == '0);
        w_c   = alu_carry_out;
        w_v   = (r_a[MSB] == w_beff[MSB]) && (alu_add[MSB] != r_a[MSB]);
        w_bad = !alu_wout;
`ifdef ALU_SEQ_DECIMAL_EN
        if (r_state == ADJ_CAPT) begin
            w_v   = (r_a[MSB] == w_beff[MSB]) && (r_bin[MSB] != r_a[MSB]);
            w_c   = (r_op == OP_ADC) ? (r_bcout || w_hi_adj) : r_bcout;
            w_bad = !alu_wout || r_werr;
        end
`endif
    end

    assign w_finish = (r_state == CAPT && !w_go_adj) || (r_state == ADJ_CAPT);

    // Completion is staged through r_fin so done lands one edge after the final capture.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_fin      <= 1'b0;
            r_p_result <= '0;
            r_p_flags  <= '0;
            r_p_mask   <= '0;
            r_p_we     <= 1'b0;
            r_p_err    <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
            r_mask     <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
            r_dec      <= 1'b0;
            r_bin      <= '0;
            r_bcout    <= 1'b0;
            r_werr     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_fin  <= 1'b0;
            if (r_fin) begin
                r_done   <= 1'b1;
                r_err    <= r_p_err;
                r_result <= r_p_result;
                r_flags  <= r_p_flags;
                r_mask   <= r_p_mask;
                r_we     <= r_p_we;
            end
            case (r_state)
                IDLE: begin
                    if (req && !r_fin) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_b   <= b;
                        r_cin <= carry_in;
`ifdef ALU_SEQ_DECIMAL_EN
                        r_dec <= dec_mode;
`endif
                        if (op <= OP_CMP) begin
                            r_state <= ISSUE;
                        end else begin
                            r_fin    <= 1'b1;
                            r_p_err  <= 1'b1;
                            r_p_we   <= 1'b0;
                            r_p_mask <= 4'b0000;
                        end
                    end
                end
                ISSUE:     r_state <= CAPT;
`ifdef ALU_SEQ_DECIMAL_EN
                CAPT: begin
                    r_bin   <= alu_add;
                    r_bcout <= alu_carry_out;
                    r_werr  <= !alu_wout;
                    if (w_go_adj) r_state <= ADJ_ISSUE;
                end
                ADJ_ISSUE: r_state <= ADJ_CAPT;
`endif
                default: ;
            endcase
            if (w_finish) begin
                r_state    <= IDLE;
                r_fin      <= 1'b1;
                r_p_result <= alu_add;
                r_p_flags  <= {w_n, w_v, w_z, w_c};
                r_p_mask   <= w_bad ? 4'b0000 : w_mask;
                r_p_we     <= !w_bad && w_we;
                r_p_err    <= w_bad;
            end
        end
    end

    assign busy       = (r_state != IDLE) || r_fin;
    assign done       = r_done;
    assign err        = r_err;
    assign result     = r_result;
    assign result_we  = r_we;
    assign flags      = r_flags;
    assign flags_mask = r_mask;

endmodule
